// File: rtl/fmap_mem_arbiter_if.sv
// Bundle of both requesters' read/write handshakes plus the shared simple-dual-port memory hookup.
// The arbiter takes the slave side; requesters and the memory wrapper sit on the master side.
interface fmap_mem_arbiter_if #(
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned BITS_PER_CHANNEL = 4,
  parameter int unsigned IMG_WIDTH        = 8,
  parameter int unsigned IMG_HEIGHT       = 8
);
  localparam int unsigned XB = $clog2(IMG_WIDTH);
  localparam int unsigned YB = $clog2(IMG_HEIGHT);
  localparam int unsigned AB = $clog2(IMG_WIDTH * IMG_HEIGHT);
  localparam int unsigned DB = CHANNELS * BITS_PER_CHANNEL;

  logic          conv_read_req;
  logic [XB-1:0] conv_read_x;
  logic [YB-1:0] conv_read_y;
  logic          conv_read_grant;
  logic          conv_read_valid;
  logic [DB-1:0] conv_read_data;
  logic          conv_write_req;
  logic [XB-1:0] conv_write_x;
  logic [YB-1:0] conv_write_y;
  logic [DB-1:0] conv_write_data;
  logic          conv_write_grant;

  logic          pool_read_req;
  logic [XB-1:0] pool_read_x;
  logic [YB-1:0] pool_read_y;
  logic          pool_read_grant;
  logic          pool_read_valid;
  logic [DB-1:0] pool_read_data;
  logic          pool_write_req;
  logic [XB-1:0] pool_write_x;
  logic [YB-1:0] pool_write_y;
  logic [DB-1:0] pool_write_data;
  logic          pool_write_grant;

  logic          mem_rd_en;
  logic [AB-1:0] mem_rd_addr;
  logic [DB-1:0] mem_rd_data;
  logic          mem_wr_en;
  logic [AB-1:0] mem_wr_addr;
  logic [DB-1:0] mem_wr_data;
  logic          range_err;

  modport slave (
    input  conv_read_req, conv_read_x, conv_read_y,
    input  conv_write_req, conv_write_x, conv_write_y, conv_write_data,
    input  pool_read_req, pool_read_x, pool_read_y,
    input  pool_write_req, pool_write_x, pool_write_y, pool_write_data,
    input  mem_rd_data,
    output conv_read_grant, conv_read_valid, conv_read_data, conv_write_grant,
    output pool_read_grant, pool_read_valid, pool_read_data, pool_write_grant,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, range_err
  );

  modport master (
    output conv_read_req, conv_read_x, conv_read_y,
    output conv_write_req, conv_write_x, conv_write_y, conv_write_data,
    output pool_read_req, pool_read_x, pool_read_y,
    output pool_write_req, pool_write_x, pool_write_y, pool_write_data,
    output mem_rd_data,
    input  conv_read_grant, conv_read_valid, conv_read_data, conv_write_grant,
    input  pool_read_grant, pool_read_valid, pool_read_data, pool_write_grant,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, range_err
  );
endinterface

// File: rtl/fmap_mem_arbiter.sv
// Round-robin arbiter sharing one feature-map memory (1R + 1W port) between conv and pool.
// Parameters must match those of the connected fmap_mem_arbiter_if instance.
module fmap_mem_arbiter #(
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned BITS_PER_CHANNEL = 4,
  parameter int unsigned IMG_WIDTH        = 8,
  parameter int unsigned IMG_HEIGHT       = 8
) (
  input logic                clk,
  input logic                reset,
  fmap_mem_arbiter_if.slave  bus
);
  localparam int unsigned XB = $clog2(IMG_WIDTH);
  localparam int unsigned YB = $clog2(IMG_HEIGHT);
  localparam int unsigned AB = $clog2(IMG_WIDTH * IMG_HEIGHT);
  localparam int unsigned DB = CHANNELS * BITS_PER_CHANNEL;

  typedef enum logic {OwnConv = 1'b0, OwnPool = 1'b1} owner_e;

  owner_e        last_rd_q, last_rd_d, last_wr_q, last_wr_d, rd_owner_q;
  logic          rd_pending_q, rd_oor_q, byp_q, range_err_q;
  logic [DB-1:0] byp_data_q;

  logic          conv_rd_gnt, pool_rd_gnt, conv_wr_gnt, pool_wr_gnt;
  logic          rd_gnt, wr_gnt, rd_in, wr_in, rd_en, wr_en, rd_hit_wr;
  logic [XB-1:0] rd_x, wr_x;
  logic [YB-1:0] rd_y, wr_y;
  logic [AB-1:0] rd_addr, wr_addr;
  logic [DB-1:0] wr_data, ret_data;
  logic          conv_vld, pool_vld;

  function automatic logic [AB-1:0] calc_addr(input logic [XB-1:0] x, input logic [YB-1:0] y);
    return AB'(y) * AB'(IMG_WIDTH) + AB'(x);
  endfunction

  function automatic logic in_range(input logic [XB-1:0] x, input logic [YB-1:0] y);
    return (32'(x) < IMG_WIDTH) && (32'(y) < IMG_HEIGHT);
  endfunction

  // On a tie the requester that did not win last time on this port takes the grant.
  always_comb begin
    conv_rd_gnt = 1'b0;
    pool_rd_gnt = 1'b0;
    conv_wr_gnt = 1'b0;
    pool_wr_gnt = 1'b0;
    if (!reset) begin
      conv_rd_gnt = bus.conv_read_req  & ~(bus.pool_read_req  & (last_rd_q == OwnConv));
      pool_rd_gnt = bus.pool_read_req  & ~(bus.conv_read_req  & (last_rd_q == OwnPool));
      conv_wr_gnt = bus.conv_write_req & ~(bus.pool_write_req & (last_wr_q == OwnConv));
      pool_wr_gnt = bus.pool_write_req & ~(bus.conv_write_req & (last_wr_q == OwnPool));
    end
    last_rd_d = last_rd_q;
    if (pool_rd_gnt)      last_rd_d = OwnPool;
    else if (conv_rd_gnt) last_rd_d = OwnConv;
    last_wr_d = last_wr_q;
    if (pool_wr_gnt)      last_wr_d = OwnPool;
    else if (conv_wr_gnt) last_wr_d = OwnConv;
  end

  always_comb begin
    rd_gnt  = conv_rd_gnt | pool_rd_gnt;
    wr_gnt  = conv_wr_gnt | pool_wr_gnt;
    rd_x    = pool_rd_gnt ? bus.pool_read_x     : bus.conv_read_x;
    rd_y    = pool_rd_gnt ? bus.pool_read_y     : bus.conv_read_y;
    wr_x    = pool_wr_gnt ? bus.pool_write_x    : bus.conv_write_x;
    wr_y    = pool_wr_gnt ? bus.pool_write_y    : bus.conv_write_y;
    wr_data = pool_wr_gnt ? bus.pool_write_data : bus.conv_write_data;
    rd_addr = calc_addr(rd_x, rd_y);
    wr_addr = calc_addr(wr_x, wr_y);
    rd_in   = in_range(rd_x, rd_y);
    wr_in   = in_range(wr_x, wr_y);
    rd_en   = rd_gnt & rd_in;
    wr_en   = wr_gnt & wr_in;
    // Memory returns old data on a same-address collision; forward the write word instead.
    rd_hit_wr = rd_en & wr_en & (rd_addr == wr_addr);
  end

  assign bus.conv_read_grant  = conv_rd_gnt;
  assign bus.pool_read_grant  = pool_rd_gnt;
  assign bus.conv_write_grant = conv_wr_gnt;
  assign bus.pool_write_grant = pool_wr_gnt;

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_en ? rd_addr : '0;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_addr = wr_en ? wr_addr : '0;
  assign bus.mem_wr_data = wr_en ? wr_data : '0;

  always_comb begin
    ret_data = bus.mem_rd_data;
    if (rd_oor_q)   ret_data = '0;
    else if (byp_q) ret_data = byp_data_q;
    conv_vld = ~reset & rd_pending_q & (rd_owner_q == OwnConv);
    pool_vld = ~reset & rd_pending_q & (rd_owner_q == OwnPool);
  end

  assign bus.conv_read_valid = conv_vld;
  assign bus.pool_read_valid = pool_vld;
  assign bus.conv_read_data  = conv_vld ? ret_data : '0;
  assign bus.pool_read_data  = pool_vld ? ret_data : '0;
  assign bus.range_err       = range_err_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_rd_q    <= OwnPool;
      last_wr_q    <= OwnPool;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OwnConv;
      rd_oor_q     <= 1'b0;
      byp_q        <= 1'b0;
      byp_data_q   <= '0;
      range_err_q  <= 1'b0;
    end else begin
      last_rd_q    <= last_rd_d;
      last_wr_q    <= last_wr_d;
      rd_pending_q <= rd_gnt;
      rd_owner_q   <= pool_rd_gnt ? OwnPool : OwnConv;
      rd_oor_q     <= rd_gnt & ~rd_in;
      byp_q        <= rd_hit_wr;
      if (rd_hit_wr) byp_data_q <= wr_data;
      range_err_q  <= range_err_q | (rd_gnt & ~rd_in) | (wr_gnt & ~wr_in);
    end
  end
endmodule

// File: tb/tb_fmap_mem_arbiter.sv
// Directed bench: 8x8 instance for arbitration, bypass and reset; a 6x7 instance for range errors,
// since 3-bit coordinates cannot leave an 8x8 map.
module tb_fmap_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fmap_mem_arbiter_if #(.CHANNELS(2), .BITS_PER_CHANNEL(4), .IMG_WIDTH(8), .IMG_HEIGHT(8)) bus ();
  fmap_mem_arbiter_if #(.CHANNELS(2), .BITS_PER_CHANNEL(4), .IMG_WIDTH(6), .IMG_HEIGHT(7)) obus ();

  fmap_mem_arbiter #(.CHANNELS(2), .BITS_PER_CHANNEL(4), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fmap_mem_arbiter #(.CHANNELS(2), .BITS_PER_CHANNEL(4), .IMG_WIDTH(6), .IMG_HEIGHT(7)) odut (
    .clk   (clk),
    .reset (reset),
    .bus   (obus)
  );

  logic [7:0] mem  [64];
  logic [7:0] omem [64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]  = 8'(i);
      omem[i] = 8'(i);
    end
  end

  // Synchronous memory: read-during-write returns the old word.
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    if (obus.mem_wr_en) omem[obus.mem_wr_addr] <= obus.mem_wr_data;
    if (obus.mem_rd_en) obus.mem_rd_data <= omem[obus.mem_rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.conv_read_req  = 1'b0; bus.conv_read_x  = '0; bus.conv_read_y  = '0;
    bus.pool_read_req  = 1'b0; bus.pool_read_x  = '0; bus.pool_read_y  = '0;
    bus.conv_write_req = 1'b0; bus.conv_write_x = '0; bus.conv_write_y = '0;
    bus.pool_write_req = 1'b0; bus.pool_write_x = '0; bus.pool_write_y = '0;
    bus.conv_write_data = '0;  bus.pool_write_data = '0;
    obus.conv_read_req  = 1'b0; obus.conv_read_x  = '0; obus.conv_read_y  = '0;
    obus.pool_read_req  = 1'b0; obus.pool_read_x  = '0; obus.pool_read_y  = '0;
    obus.conv_write_req = 1'b0; obus.conv_write_x = '0; obus.conv_write_y = '0;
    obus.pool_write_req = 1'b0; obus.pool_write_x = '0; obus.pool_write_y = '0;
    obus.conv_write_data = '0;  obus.pool_write_data = '0;
  endtask

  initial begin
    clear_reqs();
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_conv_rd_gnt", bus.conv_read_grant, 0);
    check("rst_conv_valid", bus.conv_read_valid, 0);
    check("rst_conv_data", bus.conv_read_data, 0);
    check("rst_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_mem_wr_en", bus.mem_wr_en, 0);
    check("rst_mem_wr_data", bus.mem_wr_data, 0);
    check("rst_range_err", bus.range_err, 0);
    reset = 1'b0;
    tick();

    // 1. Single conv read of (3,2) -> address 19
    bus.conv_read_req = 1'b1; bus.conv_read_x = 3'd3; bus.conv_read_y = 3'd2;
    #1;
    check("t1_conv_gnt", bus.conv_read_grant, 1);
    check("t1_pool_gnt", bus.pool_read_grant, 0);
    check("t1_rd_en", bus.mem_rd_en, 1);
    check("t1_rd_addr", bus.mem_rd_addr, 19);
    tick();
    bus.conv_read_req = 1'b0;
    #1;
    check("t1_conv_valid", bus.conv_read_valid, 1);
    check("t1_conv_data", bus.conv_read_data, 8'h13);
    check("t1_pool_valid", bus.pool_read_valid, 0);
    check("t1_pool_data", bus.pool_read_data, 0);
    check("t1_idle_rd_en", bus.mem_rd_en, 0);

    // 2. Read contention from reset: conv (1,0)=1, pool (2,0)=2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.conv_read_req = 1'b1; bus.conv_read_x = 3'd1; bus.conv_read_y = 3'd0;
    bus.pool_read_req = 1'b1; bus.pool_read_x = 3'd2; bus.pool_read_y = 3'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t2_conv_gnt%0d", i), bus.conv_read_grant, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t2_pool_gnt%0d", i), bus.pool_read_grant, (i % 2 == 0) ? 0 : 1);
      check($sformatf("t2_rd_addr%0d", i), bus.mem_rd_addr, (i % 2 == 0) ? 1 : 2);
      if (i > 0) begin
        check($sformatf("t2_conv_valid%0d", i), bus.conv_read_valid, (i % 2 == 1) ? 1 : 0);
        check($sformatf("t2_pool_valid%0d", i), bus.pool_read_valid, (i % 2 == 1) ? 0 : 1);
        check($sformatf("t2_data%0d", i), bus.conv_read_data | bus.pool_read_data,
              (i % 2 == 1) ? 1 : 2);
      end
      tick();
    end
    bus.conv_read_req = 1'b0;
    bus.pool_read_req = 1'b0;
    #1;
    check("t2_last_pool_valid", bus.pool_read_valid, 1);
    check("t2_last_pool_data", bus.pool_read_data, 2);
    check("t2_last_conv_valid", bus.conv_read_valid, 0);
    tick();

    // 3. Same-cycle pool write 0xAA and conv read at (1,1) -> address 9, write-first
    bus.pool_write_req = 1'b1; bus.pool_write_x = 3'd1; bus.pool_write_y = 3'd1;
    bus.pool_write_data = 8'hAA;
    bus.conv_read_req = 1'b1; bus.conv_read_x = 3'd1; bus.conv_read_y = 3'd1;
    #1;
    check("t3_wr_gnt", bus.pool_write_grant, 1);
    check("t3_rd_gnt", bus.conv_read_grant, 1);
    check("t3_wr_en", bus.mem_wr_en, 1);
    check("t3_wr_addr", bus.mem_wr_addr, 9);
    check("t3_wr_data", bus.mem_wr_data, 8'hAA);
    check("t3_rd_addr", bus.mem_rd_addr, 9);
    tick();
    clear_reqs();
    bus.pool_read_req = 1'b1; bus.pool_read_x = 3'd1; bus.pool_read_y = 3'd1;
    #1;
    check("t3_byp_valid", bus.conv_read_valid, 1);
    check("t3_byp_data", bus.conv_read_data, 8'hAA);
    check("t3_raw_gnt", bus.pool_read_grant, 1);
    tick();
    bus.pool_read_req = 1'b0;
    #1;
    check("t3_raw_valid", bus.pool_read_valid, 1);
    check("t3_raw_data", bus.pool_read_data, 8'hAA);
    check("t3_conv_pulse", bus.conv_read_valid, 0);
    tick();

    // 6. Write contention: conv 0x5C to (0,3)=24, pool 0x3A to (4,4)=36
    bus.conv_write_req = 1'b1; bus.conv_write_x = 3'd0; bus.conv_write_y = 3'd3;
    bus.conv_write_data = 8'h5C;
    bus.pool_write_req = 1'b1; bus.pool_write_x = 3'd4; bus.pool_write_y = 3'd4;
    bus.pool_write_data = 8'h3A;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t6_conv_wgnt%0d", i), bus.conv_write_grant, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t6_pool_wgnt%0d", i), bus.pool_write_grant, (i % 2 == 0) ? 0 : 1);
      check($sformatf("t6_wr_data%0d", i), bus.mem_wr_data, (i % 2 == 0) ? 8'h5C : 8'h3A);
      check($sformatf("t6_wr_addr%0d", i), bus.mem_wr_addr, (i % 2 == 0) ? 24 : 36);
      tick();
    end
    clear_reqs();
    tick();

    // 5. Reset one cycle after a granted read
    bus.conv_read_req = 1'b1; bus.conv_read_x = 3'd2; bus.conv_read_y = 3'd0;
    #1;
    check("t5_pre_gnt", bus.conv_read_grant, 1);
    tick();
    reset = 1'b1;
    bus.pool_write_req = 1'b1; bus.pool_write_x = 3'd2; bus.pool_write_y = 3'd2;
    bus.pool_write_data = 8'h11;
    #1;
    check("t5_rst_valid", bus.conv_read_valid, 0);
    check("t5_rst_data", bus.conv_read_data, 0);
    check("t5_rst_rd_gnt", bus.conv_read_grant, 0);
    check("t5_rst_wr_gnt", bus.pool_write_grant, 0);
    check("t5_rst_rd_en", bus.mem_rd_en, 0);
    check("t5_rst_wr_en", bus.mem_wr_en, 0);
    check("t5_rst_wr_data", bus.mem_wr_data, 0);
    tick();
    check("t5_rst_valid2", bus.conv_read_valid, 0);
    reset = 1'b0;
    bus.pool_write_req = 1'b0;
    bus.pool_read_req = 1'b1; bus.pool_read_x = 3'd3; bus.pool_read_y = 3'd0;
    #1;
    check("t5_post_valid", bus.conv_read_valid, 0);
    check("t5_tie_conv", bus.conv_read_grant, 1);
    check("t5_tie_pool", bus.pool_read_grant, 0);
    tick();
    clear_reqs();
    #1;
    check("t5_post_data", bus.conv_read_data, 2);
    check("t5_main_range_err", bus.range_err, 0);
    tick();

    // 4. Out of range on the 6x7 instance
    obus.conv_read_req = 1'b1; obus.conv_read_x = 3'd5; obus.conv_read_y = 3'd7;
    #1;
    check("t4_oor_rd_gnt", obus.conv_read_grant, 1);
    check("t4_oor_rd_en", obus.mem_rd_en, 0);
    check("t4_oor_rd_addr", obus.mem_rd_addr, 0);
    tick();
    clear_reqs();
    obus.pool_write_req = 1'b1; obus.pool_write_x = 3'd6; obus.pool_write_y = 3'd0;
    obus.pool_write_data = 8'h77;
    #1;
    check("t4_oor_valid", obus.conv_read_valid, 1);
    check("t4_oor_data", obus.conv_read_data, 0);
    check("t4_range_err", obus.range_err, 1);
    check("t4_oor_wr_gnt", obus.pool_write_grant, 1);
    check("t4_oor_wr_en", obus.mem_wr_en, 0);
    tick();
    // Pointer advanced on the out-of-range grant, so pool wins this tie; (5,6)=41 is in range
    clear_reqs();
    obus.conv_read_req = 1'b1; obus.conv_read_x = 3'd0; obus.conv_read_y = 3'd0;
    obus.pool_read_req = 1'b1; obus.pool_read_x = 3'd5; obus.pool_read_y = 3'd6;
    #1;
    check("t4_tie_pool", obus.pool_read_grant, 1);
    check("t4_tie_conv", obus.conv_read_grant, 0);
    check("t4_edge_rd_en", obus.mem_rd_en, 1);
    check("t4_edge_addr", obus.mem_rd_addr, 41);
    tick();
    clear_reqs();
    #1;
    check("t4_edge_data", obus.pool_read_data, 8'h29);
    check("t4_sticky", obus.range_err, 1);
    tick();
    tick();
    check("t4_sticky2", obus.range_err, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
